// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving the 2:1 operand mux select; optional ARB_BEAT_LIMIT_EN forces rotation after MAX_BEATS beats.
// Latency: grant/sel registered 1 cycle after request; out_valid/out_data combinational from state and inputs.
// Backpressure: out_ready low stalls the beat (no count); dropping the request abandons it, nothing is replayed.
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] x,
  input  logic             req1,
  input  logic [WIDTH-1:0] y,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state;
  logic             lp;
  logic [CNT_W-1:0] cnt;
  logic             beat;
  logic             limit_hit;

  assign out_valid = ((state == G0) && req0) || ((state == G1) && req1);
  assign out_data  = sel ? y : x;
  assign beat      = out_valid & out_ready;

`ifdef ARB_BEAT_LIMIT_EN
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  assign limit_hit = beat && (cnt == LAST_BEAT);
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= 1'b0;
      cnt   <= '0;
      lp    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          // lp==1 means requester 1 was served last, so 0 wins a tie
          if (req0 && (!req1 || lp)) begin
            state <= G0;
            gnt0  <= 1'b1;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
            lp    <= 1'b0;
          end else if (req1) begin
            state <= G1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b1;
            sel   <= 1'b1;
            lp    <= 1'b1;
          end
        end

        G0: begin
          if (!req0 || limit_hit) begin
            cnt <= '0;
            if (req1) begin
              state <= G1;
              gnt0  <= 1'b0;
              gnt1  <= 1'b1;
              sel   <= 1'b1;
              lp    <= 1'b1;
            end else if (!req0) begin
              state <= IDLE;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
            end
          end else if (beat) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        G1: begin
          if (!req1 || limit_hit) begin
            cnt <= '0;
            if (req0) begin
              state <= G0;
              gnt0  <= 1'b1;
              gnt1  <= 1'b0;
              sel   <= 1'b0;
              lp    <= 1'b0;
            end else if (!req1) begin
              state <= IDLE;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
            end
          end else if (beat) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: vector table plus beat-limit and reset-mid-grant sequences.
module tb_mux_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, req0, req1, out_ready;
  logic [W-1:0] x, y, out_data;
  logic         gnt0, gnt1, sel, out_valid;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(W), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x(x), .req1(req1), .y(y), .out_ready(out_ready),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out_valid(out_valid), .out_data(out_data)
  );

  typedef struct packed {
    logic         g0;
    logic         g1;
    logic         sl;
    logic         ov;
    logic [W-1:0] od;
  } exp_t;

  typedef struct {
    string        name;
    logic         rs, r0, r1;
    logic [W-1:0] xv, yv;
    logic         rdy;
    exp_t         e;
  } vec_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(string n, logic rs, logic r0, logic r1,
                              logic [W-1:0] xv, logic [W-1:0] yv, logic rdy,
                              logic g0, logic g1, logic sl, logic ov, logic [W-1:0] od);
    vec_t v;
    v.name = n; v.rs = rs; v.r0 = r0; v.r1 = r1;
    v.xv = xv; v.yv = yv; v.rdy = rdy;
    v.e = '{g0: g0, g1: g1, sl: sl, ov: ov, od: od};
    return v;
  endfunction

  // Inputs are held across one rising edge; outputs are checked 1ns after it.
  task automatic apply(input vec_t v);
    sb_t  s;
    exp_t got;
    @(negedge clk);
    rst = v.rs; req0 = v.r0; req1 = v.r1;
    x = v.xv; y = v.yv; out_ready = v.rdy;
    sb.push_back('{name: v.name, e: v.e});
    @(posedge clk);
    #1;
    s   = sb.pop_front();
    got = '{g0: gnt0, g1: gnt1, sl: sel, ov: out_valid, od: out_data};
    nvec++;
    if (got !== s.e) begin
      nerr++;
      $display("FAIL %s: got g0=%b g1=%b sel=%b vld=%b dat=%h, want g0=%b g1=%b sel=%b vld=%b dat=%h",
               s.name, got.g0, got.g1, got.sl, got.ov, got.od,
               s.e.g0, s.e.g1, s.e.sl, s.e.ov, s.e.od);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; x = '0; y = '0; out_ready = 1'b0;

    //              name         rst r0 r1 x      y      rdy  g0 g1 sel vld dat
    tbl.push_back(mk("rst_a",      1, 1, 1, 8'h11, 8'h22, 1,   0, 0, 0, 0, 8'h11));
    tbl.push_back(mk("rst_b",      1, 1, 1, 8'h11, 8'h22, 1,   0, 0, 0, 0, 8'h11));
    tbl.push_back(mk("rst_rel",    0, 1, 1, 8'h11, 8'h22, 1,   1, 0, 0, 1, 8'h11));
    tbl.push_back(mk("to_idle",    0, 0, 0, 8'h11, 8'h22, 1,   0, 0, 0, 0, 8'h11));
    tbl.push_back(mk("single1",    0, 0, 1, 8'h11, 8'hA5, 1,   0, 1, 1, 1, 8'hA5));
    tbl.push_back(mk("single1_b",  0, 0, 1, 8'h11, 8'hA5, 1,   0, 1, 1, 1, 8'hA5));
    tbl.push_back(mk("drop1_sel",  0, 0, 0, 8'h11, 8'hA5, 1,   0, 0, 1, 0, 8'hA5));
    tbl.push_back(mk("cont1_g0",   0, 1, 1, 8'h11, 8'h22, 1,   1, 0, 0, 1, 8'h11));
    tbl.push_back(mk("cont1_end",  0, 0, 0, 8'h11, 8'h22, 1,   0, 0, 0, 0, 8'h11));
    tbl.push_back(mk("cont2_g1",   0, 1, 1, 8'h11, 8'h22, 1,   0, 1, 1, 1, 8'h22));
    tbl.push_back(mk("cont2_end",  0, 0, 0, 8'h11, 8'h22, 1,   0, 0, 1, 0, 8'h22));
    tbl.push_back(mk("bp_grant",   0, 1, 0, 8'h3C, 8'h22, 0,   1, 0, 0, 1, 8'h3C));
    tbl.push_back(mk("bp_stall1",  0, 1, 0, 8'h3C, 8'h22, 0,   1, 0, 0, 1, 8'h3C));
    tbl.push_back(mk("bp_stall2",  0, 1, 0, 8'h3C, 8'h22, 0,   1, 0, 0, 1, 8'h3C));
    tbl.push_back(mk("bp_stall3",  0, 1, 0, 8'h3C, 8'h22, 0,   1, 0, 0, 1, 8'h3C));
    tbl.push_back(mk("bp_go1",     0, 1, 0, 8'h3C, 8'h22, 1,   1, 0, 0, 1, 8'h3C));
    tbl.push_back(mk("bp_go2",     0, 1, 0, 8'h3C, 8'h22, 1,   1, 0, 0, 1, 8'h3C));
    tbl.push_back(mk("bp_drop",    0, 0, 0, 8'h3C, 8'h22, 1,   0, 0, 0, 0, 8'h3C));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Both requesters saturated with out_ready high: rotation every 4 beats only with the limit enabled.
    apply(mk("bl_rst", 1, 1, 1, 8'h11, 8'h22, 1, 0, 0, 0, 0, 8'h11));
    for (int k = 0; k < 16; k++) begin
      logic owner;
`ifdef ARB_BEAT_LIMIT_EN
      owner = ((k / 4) % 2) == 1;
`else
      owner = 1'b0;
`endif
      apply(mk($sformatf("beat_lim_%0d", k), 0, 1, 1, 8'h11, 8'h22, 1,
               !owner, owner, owner, 1'b1, owner ? 8'h22 : 8'h11));
    end

    // Reset in the middle of a G1 grant after two beats.
    apply(mk("mg_rst",   1, 0, 1, 8'h11, 8'h22, 1, 0, 0, 0, 0, 8'h11));
    apply(mk("mg_g1",    0, 0, 1, 8'h11, 8'h22, 1, 0, 1, 1, 1, 8'h22));
    apply(mk("mg_beat1", 0, 0, 1, 8'h11, 8'h22, 1, 0, 1, 1, 1, 8'h22));
    apply(mk("mg_beat2", 0, 0, 1, 8'h11, 8'h22, 1, 0, 1, 1, 1, 8'h22));
    apply(mk("mg_reset", 1, 1, 1, 8'h11, 8'h22, 1, 0, 0, 0, 0, 8'h11));
    apply(mk("mg_after", 0, 1, 1, 8'h11, 8'h22, 1, 1, 0, 0, 1, 8'h11));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
